// File: rtl/data_req_ctrl_pkg.sv
// Shared types for the data-side request sequencer: bus access size,
// pending-FIFO entry and the issue FSM state encoding.
package data_req_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic wr;
        logic cancel;
    } pend_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } issue_state_t;

endpackage

// File: rtl/data_req_ctrl_pend_fifo.sv
// Circular FIFO of transactions past addr_ok awaiting data_ok; a broadcast
// cancel marks every stored entry so its response is later dropped.
module pend_fifo
    import data_req_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  pend_entry_t      din,
    input  logic             pop,
    input  logic             cancel_all,
    output pend_entry_t      head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pend_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // Cancelling free slots too is harmless: a push rewrites the whole entry.
            if (cancel_all)
                for (int i = 0; i < DEPTH; i++) mem[i].cancel <= 1'b1;
            if (do_push) begin
                mem[wr_ptr_reg] <= din;
                wr_ptr_reg      <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/data_req_ctrl.sv
// Latches one load/store, holds it on the SRAM-like bus until addr_ok, tracks
// outstanding transactions and returns in-order responses, dropping flushed ones.
module data_req_ctrl
    import data_req_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [2:0]  req_size,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    input  logic        flush,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        resp_valid,
    output logic        resp_wr,
    output logic [31:0] resp_rdata,
    output logic        busy
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    issue_state_t     state_reg, state_next;
    logic             pend_cancel_reg, pend_cancel_next;
    logic             wr_reg;
    mem_size_t        size_reg;
    logic [3:0]       wstrb_reg;
    logic [31:0]      addr_reg, wdata_reg;
    logic             resp_valid_reg, resp_wr_reg;
    logic [31:0]      resp_rdata_reg;
    logic [CNT_W-1:0] cnt;
    pend_entry_t      push_entry, head;
    logic             push, accept, resp_fire, fifo_empty, fifo_full;
    logic             unused_size_msb;

    assign unused_size_msb = req_size[2];

    always_comb begin
        state_next        = state_reg;
        pend_cancel_next  = pend_cancel_reg;
        push              = 1'b0;
        req_ready         = 1'b0;
        data_req          = 1'b0;
        push_entry.wr     = wr_reg;
        push_entry.cancel = flush | pend_cancel_reg;
        case (state_reg)
            ST_IDLE: begin
                req_ready        = resetn & ~flush & ~fifo_full;
                pend_cancel_next = 1'b0;
                if (req_valid & req_ready) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Never retracted: a flushed request still completes, only its response is dropped.
                data_req = 1'b1;
                if (data_addr_ok) begin
                    push             = 1'b1;
                    pend_cancel_next = 1'b0;
                    state_next       = ST_IDLE;
                end else if (flush) begin
                    pend_cancel_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept    = req_valid & req_ready;
    assign resp_fire = data_data_ok & ~head.cancel & ~flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            pend_cancel_reg <= 1'b0;
            wr_reg          <= 1'b0;
            size_reg        <= SIZE_B;
            wstrb_reg       <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            resp_valid_reg  <= 1'b0;
            resp_wr_reg     <= 1'b0;
            resp_rdata_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            pend_cancel_reg <= pend_cancel_next;
            if (accept) begin
                wr_reg    <= req_wr;
                size_reg  <= mem_size_t'(req_size[1:0]);
                wstrb_reg <= req_wstrb;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            resp_valid_reg <= resp_fire;
            resp_wr_reg    <= resp_fire & head.wr;
            resp_rdata_reg <= (resp_fire & ~head.wr) ? data_rdata : 32'h0;
        end
    end

    pend_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_pend_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push),
        .din        (push_entry),
        .pop        (data_data_ok),
        .cancel_all (flush),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (cnt)
    );

    assign data_wr    = wr_reg;
    assign data_size  = size_reg;
    assign data_addr  = addr_reg;
    assign data_wstrb = wstrb_reg;
    assign data_wdata = wdata_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_wr    = resp_wr_reg;
    assign resp_rdata = resp_rdata_reg;
    assign busy       = (state_reg == ST_ISSUE) | (cnt != '0);

    // Bus protocol violations have no recovery path.
    assert property (@(posedge clk) disable iff (!resetn) data_data_ok |-> !fifo_empty);
    assert property (@(posedge clk) disable iff (!resetn) data_addr_ok |-> (state_reg == ST_ISSUE));

endmodule

// File: tb/tb_data_req_ctrl.sv
// Directed bench for data_req_ctrl (MAX_OUTSTANDING = 2): inputs change 1ns
// after the rising edge, outputs are checked 1ns after that.
module tb_data_req_ctrl;

    logic        clk, resetn;
    logic        req_valid, req_wr, req_ready, flush;
    logic [2:0]  req_size;
    logic [3:0]  req_wstrb, data_wstrb;
    logic [31:0] req_addr, req_wdata, data_addr, data_wdata, data_rdata, resp_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok, resp_valid, resp_wr, busy;
    logic [1:0]  data_size;
    int          total = 0;
    int          bad   = 0;

    data_req_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_wstrb(req_wstrb),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rdata(resp_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request presentation; leaves the DUT in ISSUE.
    task automatic issue(input string tag, input logic wr, input logic [2:0] size,
                         input logic [3:0] wstrb, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1; req_wr = wr; req_size = size;
        req_wstrb = wstrb; req_addr = addr; req_wdata = wdata;
        #1;
        chk(tag, {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic addr_ok_cycle();
        data_addr_ok = 1'b1;
        #1;
        tick();
        data_addr_ok = 1'b0;
    endtask

    task automatic data_ok_cycle(input logic [31:0] rdata);
        data_data_ok = 1'b1; data_rdata = rdata;
        #1;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
    endtask

    task automatic expect_resp(input string tag, input logic v, input logic w, input logic [31:0] d);
        #1;
        chk(tag, {30'd0, resp_valid, resp_wr}, {30'd0, v, w});
        if (v) chk(tag, resp_rdata, d);
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 3'd0; req_wstrb = 4'h0;
        req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with a request offered while resetn is low
        req_valid = 1'b1; req_addr = 32'hFFFF_FFFF;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_ctl", {25'd0, data_req, resp_valid, resp_wr, busy, data_wr, data_size}, 32'd0);
        chk("rst_payload", data_addr | data_wdata | {28'd0, data_wstrb} | resp_rdata, 32'd0);
        chk("rst_cnt", {30'd0, dut.cnt}, 32'd0);
        req_valid = 1'b0; req_addr = 32'h0; resetn = 1'b1;
        tick();

        // Single load: addr_ok 2 cycles after data_req, data_ok 3 cycles after addr_ok
        issue("t1_ready", 1'b0, 3'd2, 4'h0, 32'h8000_0010, 32'h0);
        #1;
        chk("t1_dreq", {31'd0, data_req}, 32'd1);
        chk("t1_addr", data_addr, 32'h8000_0010);
        chk("t1_ctl", {29'd0, data_wr, data_size}, {29'd0, 1'b0, 2'd2});
        chk("t1_ready_issue", {31'd0, req_ready}, 32'd0);
        tick();
        addr_ok_cycle();
        #1;
        chk("t1_dreq_low", {31'd0, data_req}, 32'd0);
        chk("t1_cnt", {30'd0, dut.cnt}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        data_ok_cycle(32'hDEAD_BEEF);
        expect_resp("t1_resp", 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("t1_cnt0", {30'd0, dut.cnt}, 32'd0);
        tick();
        expect_resp("t1_pulse", 1'b0, 1'b0, 32'h0);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // Store stability while addr_ok is held low
        issue("t2_ready", 1'b1, 3'd0, 4'h4, 32'h1000_0002, 32'h0055_0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_ctl", {24'd0, data_req, data_wr, data_size, data_wstrb}, {24'd0, 1'b1, 1'b1, 2'd0, 4'h4});
            chk("t2_addr", data_addr, 32'h1000_0002);
            chk("t2_wdata", data_wdata, 32'h0055_0000);
            tick();
        end
        addr_ok_cycle();
        tick();
        data_ok_cycle(32'h1234_5678);
        expect_resp("t2_resp", 1'b1, 1'b1, 32'h0);

        // Full: two pushes fill the FIFO, third load waits for first data_ok
        issue("t3a_ready", 1'b0, 3'd2, 4'h0, 32'h0000_0200, 32'h0);
        addr_ok_cycle();
        issue("t3b_ready", 1'b0, 3'd2, 4'h0, 32'h0000_0204, 32'h0);
        addr_ok_cycle();
        req_valid = 1'b1; req_addr = 32'h0000_0208;
        #1;
        chk("t3_full_ready", {31'd0, req_ready}, 32'd0);
        chk("t3_cnt2", {30'd0, dut.cnt}, 32'd2);
        tick();
        #1;
        chk("t3_full_ready2", {31'd0, req_ready}, 32'd0);
        chk("t3_no_issue", {31'd0, data_req}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h0000_00A0;
        tick();
        data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("t3_ready_after", {31'd0, req_ready}, 32'd1);
        chk("t3_resp0", {31'd0, resp_valid}, 32'd1);
        chk("t3_rdata0", resp_rdata, 32'h0000_00A0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("t3_issue3", {31'd0, data_req}, 32'd1);
        chk("t3_addr3", data_addr, 32'h0000_0208);
        // addr_ok and data_ok together: count holds
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0000_00A1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        #1;
        chk("t3_cnt_same", {30'd0, dut.cnt}, 32'd1);
        chk("t3_resp1", resp_rdata, 32'h0000_00A1);
        chk("t3_valid1", {31'd0, resp_valid}, 32'd1);
        data_ok_cycle(32'h0000_00A2);
        expect_resp("t3_resp2", 1'b1, 1'b0, 32'h0000_00A2);
        chk("t3_cnt0", {30'd0, dut.cnt}, 32'd0);

        // Flush with two pending entries
        issue("t4a_ready", 1'b0, 3'd2, 4'h0, 32'h0000_0300, 32'h0);
        addr_ok_cycle();
        issue("t4b_ready", 1'b0, 3'd2, 4'h0, 32'h0000_0304, 32'h0);
        addr_ok_cycle();
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        data_ok_cycle(32'h0000_0011);
        expect_resp("t4_drop0", 1'b0, 1'b0, 32'h0);
        data_ok_cycle(32'h0000_0022);
        expect_resp("t4_drop1", 1'b0, 1'b0, 32'h0);
        chk("t4_cnt0", {30'd0, dut.cnt}, 32'd0);
        issue("t4c_ready", 1'b0, 3'd1, 4'h0, 32'h0000_0308, 32'h0);
        addr_ok_cycle();
        data_ok_cycle(32'h5555_AAAA);
        expect_resp("t4_after", 1'b1, 1'b0, 32'h5555_AAAA);

        // Flush during ISSUE before addr_ok
        issue("t5_ready", 1'b0, 3'd2, 4'h0, 32'h0000_0400, 32'h0);
        flush = 1'b1;
        #1;
        chk("t5_dreq_flush", {31'd0, data_req}, 32'd1);
        tick();
        flush = 1'b0;
        #1;
        chk("t5_dreq_hold", {31'd0, data_req}, 32'd1);
        chk("t5_pend", {31'd0, dut.pend_cancel_reg}, 32'd1);
        chk("t5_addr", data_addr, 32'h0000_0400);
        tick();
        addr_ok_cycle();
        #1;
        chk("t5_pushed", {30'd0, dut.cnt}, 32'd1);
        chk("t5_pend_clr", {31'd0, dut.pend_cancel_reg}, 32'd0);
        data_ok_cycle(32'h0000_0077);
        expect_resp("t5_drop", 1'b0, 1'b0, 32'h0);

        // Flush in the same cycle as addr_ok
        issue("t5b_ready", 1'b0, 3'd2, 4'h0, 32'h0000_0404, 32'h0);
        data_addr_ok = 1'b1; flush = 1'b1;
        #1;
        tick();
        data_addr_ok = 1'b0; flush = 1'b0;
        data_ok_cycle(32'h0000_0088);
        expect_resp("t5b_drop", 1'b0, 1'b0, 32'h0);

        // Flush together with data_ok
        issue("t6_ready", 1'b0, 3'd2, 4'h0, 32'h0000_0500, 32'h0);
        addr_ok_cycle();
        data_data_ok = 1'b1; flush = 1'b1; data_rdata = 32'h0000_0099;
        #1;
        tick();
        data_data_ok = 1'b0; flush = 1'b0; data_rdata = 32'h0;
        expect_resp("t6_drop", 1'b0, 1'b0, 32'h0);
        chk("t6_cnt0", {30'd0, dut.cnt}, 32'd0);

        // Flush blocks acceptance in IDLE
        req_valid = 1'b1; flush = 1'b1; req_addr = 32'h0000_0510;
        #1;
        chk("t6_flush_ready", {31'd0, req_ready}, 32'd0);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        #1;
        chk("t6_no_issue", {31'd0, data_req}, 32'd0);

        // Reset while in ISSUE
        issue("t7_ready", 1'b1, 3'd1, 4'h3, 32'h0000_0600, 32'h0000_ABCD);
        #1;
        chk("t7_dreq", {31'd0, data_req}, 32'd1);
        resetn = 1'b0;
        tick();
        #1;
        chk("t7_dreq_rst", {31'd0, data_req}, 32'd0);
        chk("t7_ready_rst", {31'd0, req_ready}, 32'd0);
        chk("t7_payload", data_addr | data_wdata, 32'd0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        tick();
        #1;
        chk("t7_ready_back", {31'd0, req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_req_ctrl.md
# data_req_ctrl

Sequencer between the memory-stage request generator and the SRAM-like data bus. It latches one load/store request and holds it stable on the bus until `data_addr_ok`. It tracks up to `MAX_OUTSTANDING` accepted-but-unanswered transactions and returns each `data_data_ok` response to the pipeline in order. On a pipeline flush it cancels in-flight responses, so only the controller sees them and the pipeline never does.

## Interface
Reset is synchronous and active-low; there is one clock. Parameters:
- `MAX_OUTSTANDING`, default 2: maximum number of transactions past `addr_ok` awaiting `data_ok`. Legal values are 1 to 4.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in 1: memory stage presents a request.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_size` in 3: 0 = byte, 1 = half, 2 = word. Bit 2 is ignored.
- `req_wstrb` in 4: byte write strobes (stores).
- `req_addr` in 32: byte address. Already word-aligned for LWL/LWR/SWL/SWR.
- `req_wdata` in 32: lane-aligned store data.
- `req_ready` out 1: request accepted this cycle (valid & ready).
- `flush` in 1: exception or ERET flush. Cancels all outstanding responses.
- `data_req` out 1: bus request.
- `data_wr` out 1: bus write flag.
- `data_size` out 2: bus size, equal to `req_size[1:0]`.
- `data_addr` out 32: bus address.
- `data_wstrb` out 4: bus write strobes.
- `data_wdata` out 32: bus write data.
- `data_addr_ok` in 1: bus accepted the address phase.
- `data_data_ok` in 1: bus returns data (load) or write acknowledge (store).
- `data_rdata` in 32: load data.
- `resp_valid` out 1: one-cycle response pulse to the pipeline.
- `resp_wr` out 1: the response belongs to a store.
- `resp_rdata` out 32: load data. Zero for stores.
- `busy` out 1: request register full or outstanding count nonzero.

## Operation
- **Issue FSM, IDLE.**
  - `data_req` = 0.
  - `req_ready` = `resetn & ~flush & (cnt < MAX_OUTSTANDING)`.
  - On `req_valid & req_ready`: latch all `req_*` into the request register and go to ISSUE.
- **Issue FSM, ISSUE.**
  - `data_req` = 1. `data_*` are driven from the request register and stay stable.
  - `req_ready` = 0.
  - On `data_addr_ok`: push `{wr, cancel}` into the pending FIFO, `cnt++`, return to IDLE.
  - `cancel` = 1 if `flush` is in this cycle, or if a flush occurred while the request sat in ISSUE.
- **No retraction.** An issued request is never withdrawn, even on flush. It completes on the bus and its response is dropped.
- **Sticky cancel.** While in ISSUE, `flush` sets a `pend_cancel` flag. The flag clears when `addr_ok` pushes the entry.
- **Flush of pending entries.** `flush` sets `cancel` on every valid entry in the pending FIFO in the same cycle.
- **Response path.** On `data_data_ok`:
  - Pop the FIFO head and `cnt--`.
  - If the head is not cancelled and there is no `flush` this cycle, register `resp_valid` = 1, `resp_wr` = head.wr, and `resp_rdata` = head.wr ? 0 : `data_rdata`.
- **Count rules.**
  - `addr_ok` and `data_ok` in the same cycle: push and pop, `cnt` unchanged.
  - `cnt` never exceeds `MAX_OUTSTANDING`. `cnt` is `$clog2(MAX_OUTSTANDING+1)` bits wide.
- **Bus protocol violations (assertion, no recovery).**
  - `data_data_ok` while `cnt` = 0.
  - `data_addr_ok` while not in ISSUE.
  - `data_ok` for a transaction in the same cycle as its own `addr_ok` is not supported.

## Timing
- **Reset values.** With `resetn` low at a clock edge, the following hold after that edge:
  - FSM = IDLE, `cnt` = 0, FIFO empty, `pend_cancel` = 0.
  - `data_req` = 0, `resp_valid` = 0, `resp_wr` = 0, `resp_rdata` = 0, `busy` = 0.
  - All `data_*` payload outputs = 0.
- **During reset.** `req_ready` is 0 while `resetn` is low.
- **Issue latency.** Accept in cycle N; `data_req` is high in cycle N+1 at the earliest.
- **Response latency.** `data_data_ok` in cycle M gives `resp_valid` in cycle M+1, for exactly one cycle per response.
- **Back-to-back issue.** `addr_ok` in cycle N returns the FSM to IDLE in N+1. The next request can be accepted in N+1, so the issue rate is at most one request per two cycles.
- **Full.** With `cnt` = `MAX_OUTSTANDING`, `req_ready` stays 0 until a `data_ok` decrements `cnt`. `req_ready` rises in the cycle after that `data_ok`.
- **Reset mid-transaction.** Reset discards all state. The bus side is reset concurrently, so no late `data_ok` is expected.

## Structure
- **Shared CPU package** (`cpu.svh` side) holds:
  - `mem_size_t` enum (`SIZE_B`, `SIZE_H`, `SIZE_W`).
  - `pend_entry_t` struct `{logic wr; logic cancel;}`.
- **Sub-module `pend_fifo`:** parameterised-depth circular FIFO of `pend_entry_t`. It has:
  - push and pop ports, usable in the same cycle;
  - a broadcast `cancel_all` input;
  - `head`, `empty` and `full` outputs;
  - wrap-around read and write pointers plus a count.
- **Top level** holds the two-state issue FSM, the request register and the response register.

## Test plan
- **Single load.** Load to 0x8000_0010; `addr_ok` 2 cycles after `data_req`; `data_ok` with rdata 0xDEAD_BEEF 3 cycles later.
  - Expect one `resp_valid` pulse with `resp_rdata` = 0xDEAD_BEEF and `resp_wr` = 0.
- **Store stability.** SB, wstrb 0x4, wdata 0x0055_0000; `addr_ok` held low for 5 cycles.
  - Expect `data_*` constant throughout.
  - Expect `resp_valid` with `resp_wr` = 1 and `resp_rdata` = 0 after `data_ok`.
- **Full.** `MAX_OUTSTANDING` = 2; three loads back-to-back; `addr_ok` immediate; `data_ok` withheld.
  - Expect `req_ready` = 0 after 2 pushes and `cnt` = 2.
  - First `data_ok` gives `req_ready` = 1 in the next cycle.
  - Responses return in order.
- **Flush with pending entries.** Flush with 2 pending entries.
  - Expect both `data_ok` to produce no `resp_valid` and `cnt` to return to 0.
  - A new load issued afterwards responds normally.
- **Flush during ISSUE.** Flush while in ISSUE before `addr_ok`.
  - Expect `data_req` to stay high until `addr_ok` and the entry to be pushed with cancel = 1.
  - Expect its `data_ok` to be dropped.
- **Simultaneous events.** `addr_ok` and `data_ok` in the same cycle: expect `cnt` unchanged.
  - `flush` with `data_ok` in the same cycle: expect no `resp_valid`.
  - `resetn` low mid-ISSUE: expect `data_req` = 0 on the next cycle.
